// File: rtl/uart_reg_responder_pkg.sv
// Shared types and protocol constants for the UART register responder.
package uart_reg_responder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR,
        W_DATA,
        R_ADDR,
        READ,
        RESP
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;

    // An address byte is usable only if every bit above the bus width is zero.
    function automatic logic addr_in_range(input logic [7:0] addr, input int addr_bits);
        return (addr >> addr_bits) == 8'h00;
    endfunction

endpackage

// File: rtl/uart_reg_responder_if.sv
// Byte-stream handshakes plus register bus between responder and its environment.
interface uart_reg_responder_if #(
    parameter int ADDR_BITS = 4
);
    logic                 rx_valid;
    logic                 rx_ready;
    logic [7:0]           rx_bits;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [7:0]           tx_bits;
    logic                 reg_write;
    logic                 reg_read;
    logic [ADDR_BITS-1:0] reg_address;
    logic [7:0]           reg_wdata;
    logic [7:0]           reg_rdata;

    modport master (
        input  rx_valid, rx_bits, tx_ready, reg_rdata,
        output rx_ready, tx_valid, tx_bits, reg_write, reg_read, reg_address, reg_wdata
    );

    modport slave (
        output rx_valid, rx_bits, tx_ready, reg_rdata,
        input  rx_ready, tx_valid, tx_bits, reg_write, reg_read, reg_address, reg_wdata
    );
endinterface

// File: rtl/uart_frame_timer.sv
// Inter-byte watchdog: counts enabled cycles and flags the last allowed one.
module uart_frame_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A zero limit disables expiry entirely.
    assign o_expired = (TIMEOUT_CYCLES != 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/uart_reg_responder.sv
// Parses 'W' addr data / 'R' addr byte frames into register-bus strobes and ACK/NAK/data replies.
module uart_reg_responder
    import uart_reg_responder_pkg::*;
#(
    parameter int ADDR_BITS      = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clock,
    input  logic                 reset,
    uart_reg_responder_if.master bus,
    output logic                 busy,
    output logic                 frame_error
);
    state_t               r_state;
    logic                 r_rx_ready;
    logic                 r_tx_valid;
    logic [7:0]           r_tx_bits;
    logic                 r_reg_write;
    logic                 r_reg_read;
    logic [ADDR_BITS-1:0] r_reg_address;
    logic [7:0]           r_reg_wdata;
    logic [7:0]           r_addr;
    logic                 r_busy;
    logic                 r_frame_error;

    logic w_rx_fire;
    logic w_tx_fire;
    logic w_listen;
    logic w_expired;

    assign w_rx_fire = bus.rx_valid && r_rx_ready;
    assign w_tx_fire = r_tx_valid && bus.tx_ready;
    assign w_listen  = (r_state == W_ADDR) || (r_state == W_DATA) || (r_state == R_ADDR);

    uart_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_rx_fire || !w_listen),
        .i_enable (w_listen),
        .o_expired(w_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_rx_ready    <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_tx_bits     <= '0;
            r_reg_write   <= 1'b0;
            r_reg_read    <= 1'b0;
            r_reg_address <= '0;
            r_reg_wdata   <= '0;
            r_addr        <= '0;
            r_busy        <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_reg_write   <= 1'b0;
            r_reg_read    <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    // rx_ready is held low for the first cycle out of reset.
                    r_rx_ready <= 1'b1;
                    if (w_rx_fire) begin
                        r_busy <= 1'b1;
                        if (bus.rx_bits == CMD_WRITE) begin
                            r_state <= W_ADDR;
                        end else if (bus.rx_bits == CMD_READ) begin
                            r_state <= R_ADDR;
                        end else begin
                            r_state       <= RESP;
                            r_rx_ready    <= 1'b0;
                            r_tx_valid    <= 1'b1;
                            r_tx_bits     <= RESP_NAK;
                            r_frame_error <= 1'b1;
                        end
                    end
                end
                W_ADDR: begin
                    if (w_rx_fire) begin
                        r_addr  <= bus.rx_bits;
                        r_state <= W_DATA;
                    end else if (w_expired) begin
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_frame_error <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_rx_fire) begin
                        r_state    <= RESP;
                        r_rx_ready <= 1'b0;
                        r_tx_valid <= 1'b1;
                        if (addr_in_range(r_addr, ADDR_BITS)) begin
                            r_reg_write   <= 1'b1;
                            r_reg_address <= r_addr[ADDR_BITS-1:0];
                            r_reg_wdata   <= bus.rx_bits;
                            r_tx_bits     <= RESP_ACK;
                        end else begin
                            r_tx_bits     <= RESP_NAK;
                            r_frame_error <= 1'b1;
                        end
                    end else if (w_expired) begin
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_frame_error <= 1'b1;
                    end
                end
                R_ADDR: begin
                    if (w_rx_fire) begin
                        r_rx_ready <= 1'b0;
                        if (addr_in_range(bus.rx_bits, ADDR_BITS)) begin
                            r_state       <= READ;
                            r_reg_read    <= 1'b1;
                            r_reg_address <= bus.rx_bits[ADDR_BITS-1:0];
                        end else begin
                            r_state       <= RESP;
                            r_tx_valid    <= 1'b1;
                            r_tx_bits     <= RESP_NAK;
                            r_frame_error <= 1'b1;
                        end
                    end else if (w_expired) begin
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_frame_error <= 1'b1;
                    end
                end
                READ: begin
                    r_state    <= RESP;
                    r_tx_valid <= 1'b1;
                    r_tx_bits  <= bus.reg_rdata;
                end
                RESP: begin
                    if (w_tx_fire) begin
                        r_state    <= IDLE;
                        r_tx_valid <= 1'b0;
                        r_rx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_ready    = r_rx_ready;
    assign bus.tx_valid    = r_tx_valid;
    assign bus.tx_bits     = r_tx_bits;
    assign bus.reg_write   = r_reg_write;
    assign bus.reg_read    = r_reg_read;
    assign bus.reg_address = r_reg_address;
    assign bus.reg_wdata   = r_reg_wdata;
    assign busy            = r_busy;
    assign frame_error     = r_frame_error;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed vector table plus corner-case sequences and a scoreboarded random run for uart_reg_responder.
module tb_uart_reg_responder;
    import uart_reg_responder_pkg::*;

    localparam int AB = 4;
    localparam int TO = 100;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic busy;
    logic frame_error;

    uart_reg_responder_if #(.ADDR_BITS(AB)) bus ();

    uart_reg_responder #(
        .ADDR_BITS     (AB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // User-logic register file seen by the DUT.
    logic [7:0] env_regs [16] = '{3: 8'hA5, default: 8'h00};
    assign bus.reg_rdata = env_regs[bus.reg_address];
    always @(posedge clock) if (bus.reg_write) env_regs[bus.reg_address] <= bus.reg_wdata;

    // Bench-side expected register contents.
    logic [7:0] exp_regs [16];

    int         wr_cnt = 0, rd_cnt = 0, fe_cnt = 0, long_pulse = 0;
    logic [3:0] wr_addr = '0, rd_addr = '0;
    logic [7:0] wr_data = '0;
    logic       prev_wr = 1'b0, prev_rd = 1'b0, prev_fe = 1'b0;

    always @(negedge clock) begin
        if (bus.reg_write) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= bus.reg_address;
            wr_data <= bus.reg_wdata;
        end
        if (bus.reg_read) begin
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= bus.reg_address;
        end
        if (frame_error) fe_cnt <= fe_cnt + 1;
        if ((bus.reg_write && prev_wr) || (bus.reg_read && prev_rd) || (frame_error && prev_fe))
            long_pulse <= long_pulse + 1;
        prev_wr <= bus.reg_write;
        prev_rd <= bus.reg_read;
        prev_fe <= frame_error;
    end

    typedef struct {
        int unsigned     n;
        logic [2:0][7:0] b;
        logic [7:0]      resp;
        int              lat;
        int              wr;
        int              rd;
        int              fe;
        logic [3:0]      addr;
        logic [7:0]      wdata;
    } vec_t;

    function automatic vec_t mk(input int unsigned n, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] resp, input int lat,
                                input int wr, input int rd, input int fe,
                                input logic [3:0] addr, input logic [7:0] wdata);
        vec_t v;
        v.n = n; v.b = {b2, b1, b0}; v.resp = resp; v.lat = lat;
        v.wr = wr; v.rd = rd; v.fe = fe; v.addr = addr; v.wdata = wdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        repeat (gap) @(negedge clock);
        bus.rx_valid = 1'b1;
        bus.rx_bits  = b;
        for (int i = 0; i < 200 && !bus.rx_ready; i++) @(negedge clock);
        if (!bus.rx_ready) begin
            checks++;
            errors++;
            $display("FAIL rx_accept: rx_ready stayed 0 for 200 cycles, expected 1 (byte %0h)", b);
        end else begin
            @(posedge clock);
            @(negedge clock);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic get_resp(input logic [7:0] exp, input int exp_lat, input bit rnd, input string tag);
        int lat = 0;
        bit done = 1'b0;
        if (rnd) bus.tx_ready = 1'b0;
        while (!bus.tx_valid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd1);
        if (bus.tx_valid) begin
            check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            for (int i = 0; i < 200 && !done; i++) begin
                bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.tx_ready) begin
                    check({tag, "_tx_bits"}, 32'(bus.tx_bits), 32'(exp));
                    check({tag, "_rx_ready_in_resp"}, 32'(bus.rx_ready), 32'd0);
                    done = 1'b1;
                end
                @(negedge clock);
            end
            check({tag, "_tx_drop"}, 32'(bus.tx_valid), 32'd0);
        end
        bus.tx_ready = 1'b1;
    endtask

    task automatic run_cmd(input vec_t v, input bit rnd, input string tag);
        int wr0 = wr_cnt;
        int rd0 = rd_cnt;
        int fe0 = fe_cnt;
        for (int i = 0; i < int'(v.n); i++) send_byte(v.b[i], rnd ? $urandom_range(0, 3) : 0);
        get_resp(v.resp, v.lat, rnd, tag);
        check({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(v.wr));
        check({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(v.rd));
        check({tag, "_frame_err"}, 32'(fe_cnt - fe0), 32'(v.fe));
        if (v.wr != 0) begin
            check({tag, "_waddr"}, 32'(wr_addr), 32'(v.addr));
            check({tag, "_wdata"}, 32'(wr_data), 32'(v.wdata));
            exp_regs[v.addr] = v.wdata;
        end
        if (v.rd != 0) check({tag, "_raddr"}, 32'(rd_addr), 32'(v.addr));
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   wr0, rd0, fe0, stable_err;
        vec_t v;

        bus.rx_valid = 1'b0;
        bus.rx_bits  = '0;
        bus.tx_ready = 1'b1;
        foreach (exp_regs[i]) exp_regs[i] = 8'h00;
        exp_regs[3] = 8'hA5;

        vecs[0]  = mk(3, 8'h57, 8'h03, 8'hA5, RESP_ACK, 0, 1, 0, 0, 4'h3, 8'hA5);
        vecs[1]  = mk(2, 8'h52, 8'h03, 8'h00, 8'hA5,    1, 0, 1, 0, 4'h3, 8'h00);
        vecs[2]  = mk(1, 8'h41, 8'h00, 8'h00, RESP_NAK, 0, 0, 0, 1, 4'h0, 8'h00);
        vecs[3]  = mk(3, 8'h57, 8'h20, 8'h11, RESP_NAK, 0, 0, 0, 1, 4'h0, 8'h00);
        vecs[4]  = mk(2, 8'h52, 8'hFF, 8'h00, RESP_NAK, 0, 0, 0, 1, 4'h0, 8'h00);
        vecs[5]  = mk(2, 8'h52, 8'h10, 8'h00, RESP_NAK, 0, 0, 0, 1, 4'h0, 8'h00);
        vecs[6]  = mk(3, 8'h57, 8'h0F, 8'h7E, RESP_ACK, 0, 1, 0, 0, 4'hF, 8'h7E);
        vecs[7]  = mk(2, 8'h52, 8'h0F, 8'h00, 8'h7E,    1, 0, 1, 0, 4'hF, 8'h00);
        vecs[8]  = mk(3, 8'h57, 8'h00, 8'hC3, RESP_ACK, 0, 1, 0, 0, 4'h0, 8'hC3);
        vecs[9]  = mk(2, 8'h52, 8'h00, 8'h00, 8'hC3,    1, 0, 1, 0, 4'h0, 8'h00);
        vecs[10] = mk(2, 8'h52, 8'h07, 8'h00, 8'h00,    1, 0, 1, 0, 4'h7, 8'h00);
        vecs[11] = mk(1, 8'h00, 8'h00, 8'h00, RESP_NAK, 0, 0, 0, 1, 4'h0, 8'h00);

        // Reset state
        repeat (2) @(negedge clock);
        check("reset_outputs", 32'({bus.rx_ready, bus.tx_valid, bus.tx_bits, bus.reg_write, bus.reg_read,
                                    bus.reg_address, bus.reg_wdata, busy, frame_error}), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("post_reset_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("post_reset_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 12; i++) run_cmd(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Backpressure: response held for 50 cycles
        rd0 = rd_cnt;
        bus.tx_ready = 1'b0;
        send_byte(8'h52, 0);
        send_byte(8'h03, 0);
        for (int i = 0; i < 10 && !bus.tx_valid; i++) @(negedge clock);
        stable_err = 0;
        for (int i = 0; i < 50; i++) begin
            if (!bus.tx_valid || bus.tx_bits !== 8'hA5 || bus.rx_ready || !busy) stable_err++;
            @(negedge clock);
        end
        check("bp_stable", 32'(stable_err), 32'd0);
        check("bp_reads", 32'(rd_cnt - rd0), 32'd1);
        bus.tx_ready = 1'b1;
        @(negedge clock);
        check("bp_tx_drop", 32'(bus.tx_valid), 32'd0);
        run_cmd(mk(3, 8'h57, 8'h01, 8'h02, RESP_ACK, 0, 1, 0, 0, 4'h1, 8'h02), 1'b0, "bp_follow");

        // Timeout after a lone write command byte
        wr0 = wr_cnt;
        fe0 = fe_cnt;
        send_byte(8'h57, 0);
        repeat (99) @(negedge clock);
        check("to_early_fe", 32'(frame_error), 32'd0);
        check("to_early_busy", 32'(busy), 32'd1);
        @(negedge clock);
        check("to_fe_pulse", 32'(frame_error), 32'd1);
        check("to_busy_clear", 32'(busy), 32'd0);
        repeat (5) @(negedge clock);
        check("to_no_resp", 32'(bus.tx_valid), 32'd0);
        check("to_no_write", 32'(wr_cnt - wr0), 32'd0);
        check("to_fe_count", 32'(fe_cnt - fe0), 32'd1);
        run_cmd(mk(2, 8'h52, 8'h01, 8'h00, 8'h02, 1, 0, 1, 0, 4'h1, 8'h00), 1'b0, "to_follow");

        // Async reset between address and data of a write
        wr0 = wr_cnt;
        send_byte(8'h57, 0);
        send_byte(8'h05, 0);
        @(posedge clock);
        #2 reset = 1'b0;
        #1 check("rst_mid_outputs", 32'({bus.rx_ready, bus.tx_valid, bus.tx_bits, bus.reg_write, bus.reg_read,
                                         bus.reg_address, bus.reg_wdata, busy, frame_error}), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_no_write", 32'(wr_cnt - wr0), 32'd0);
        run_cmd(mk(3, 8'h57, 8'h05, 8'h3C, RESP_ACK, 0, 1, 0, 0, 4'h5, 8'h3C), 1'b0, "rst_write");
        run_cmd(mk(2, 8'h52, 8'h05, 8'h00, 8'h3C, 1, 0, 1, 0, 4'h5, 8'h00), 1'b0, "rst_read");

        // Async reset while a response is pending
        bus.tx_ready = 1'b0;
        send_byte(8'h41, 0);
        check("rst_resp_pending", 32'(bus.tx_valid), 32'd1);
        #2 reset = 1'b0;
        #1 check("rst_resp_drop", 32'(bus.tx_valid), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        bus.tx_ready = 1'b1;
        @(negedge clock);

        // Random commands with random gaps and tx backpressure
        for (int k = 0; k < 300; k++) begin
            int unsigned kind  = $urandom_range(0, 9);
            logic [7:0]  a     = 8'($urandom_range(0, 15));
            logic [7:0]  d     = 8'($urandom_range(0, 255));
            logic [7:0]  c     = 8'($urandom_range(0, 255));
            logic [7:0]  big   = 8'($urandom_range(16, 255));
            if (kind <= 3) begin
                v = mk(3, 8'h57, a, d, RESP_ACK, 0, 1, 0, 0, a[3:0], d);
            end else if (kind <= 7) begin
                v = mk(2, 8'h52, a, 8'h00, exp_regs[a[3:0]], 1, 0, 1, 0, a[3:0], 8'h00);
            end else if (kind == 8) begin
                if (c == CMD_WRITE || c == CMD_READ) c = c ^ 8'h01;
                v = mk(1, c, 8'h00, 8'h00, RESP_NAK, 0, 0, 0, 1, 4'h0, 8'h00);
            end else if (d[0]) begin
                v = mk(3, 8'h57, big, d, RESP_NAK, 0, 0, 0, 1, 4'h0, 8'h00);
            end else begin
                v = mk(2, 8'h52, big, 8'h00, RESP_NAK, 0, 0, 0, 1, 4'h0, 8'h00);
            end
            run_cmd(v, 1'b1, $sformatf("rnd%0d", k));
        end

        check("strobe_width", 32'(long_pulse), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
